// File: rtl/fifo_pkg.sv
// Shared types and constants for the async-FIFO read-side controller.
// FLUSH_WAIT exists only when FIFO_RD_FLUSH_EN is defined.
package fifo_pkg;

  localparam int unsigned SKID_DEPTH  = 2;
  localparam int unsigned FIFO_RD_LAT = 1;
  localparam int unsigned OCC_W       = $clog2(SKID_DEPTH + 1);

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
`ifdef FIFO_RD_FLUSH_EN
    FLUSH_WAIT = 2'd2,
`endif
    ACTIVE     = 2'd1
  } rd_state_e;

endpackage

// File: rtl/fifo_rd_skid.sv
// Two-entry in-order skid buffer: d0 is always the head, d1 the word behind it.
module fifo_rd_skid
  import fifo_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic             pop,
  input  logic             clear,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] head,
  output logic [OCC_W-1:0] occ
);

  logic [WIDTH-1:0] d0;
  logic [WIDTH-1:0] d1;

  // Clear wins over push/pop; a simultaneous push+pop keeps occupancy and order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      d0  <= '0;
      d1  <= '0;
      occ <= '0;
    end else if (clear) begin
      occ <= '0;
    end else begin
      case ({push, pop})
        2'b10: begin
          if (occ == '0) d0 <= din;
          else           d1 <= din;
          occ <= occ + OCC_W'(1);
        end
        2'b01: begin
          d0  <= d1;
          occ <= occ - OCC_W'(1);
        end
        2'b11: begin
          if (occ == OCC_W'(1)) begin
            d0 <= din;
          end else begin
            d0 <= d1;
            d1 <= din;
          end
        end
        default: ;
      endcase
    end
  end

  assign head = d0;

  a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
    occ <= OCC_W'(SKID_DEPTH));

endmodule

// File: rtl/fifo_read_ctrl.sv
// Read-side FIFO drain controller presenting words on a valid/ready stream.
// Optional flush/discard path enabled by defining FIFO_RD_FLUSH_EN.
module fifo_read_ctrl
  import fifo_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             empty_flag,
  input  logic [WIDTH-1:0] data_out,
  output logic             r_en,
  output logic [WIDTH-1:0] m_data,
  output logic             m_valid,
  input  logic             m_ready,
  output logic [CNT_W-1:0] rd_count
`ifdef FIFO_RD_FLUSH_EN
  ,
  input  logic             flush,
  output logic             flush_done
`endif
);

  localparam int unsigned LVL_W = OCC_W + 1;

  rd_state_e              state;
  rd_state_e              state_nxt;
  logic [FIFO_RD_LAT-1:0] infl;
  logic [OCC_W-1:0]       occ;
  logic [LVL_W-1:0]       lvl;
  logic                   pop;
  logic                   push;
  logic                   clear;
  logic                   flushing;

  assign m_valid = (occ != '0);
  assign pop     = m_valid && m_ready;
  // Words held or already committed once this cycle's pop is accounted for.
  assign lvl     = LVL_W'(occ) + LVL_W'(infl) - LVL_W'(pop);

`ifdef FIFO_RD_FLUSH_EN
  logic flush_done_nxt;

  assign flushing = (state == FLUSH_WAIT);
  assign clear    = flush && !flushing;
`else
  assign flushing = 1'b0;
  assign clear    = 1'b0;
`endif

  // Arriving words are discarded while draining for a flush.
  assign push = infl[FIFO_RD_LAT-1] && !flushing;

  fifo_rd_skid #(
    .WIDTH(WIDTH)
  ) u_skid (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .pop   (pop),
    .clear (clear),
    .din   (data_out),
    .head  (m_data),
    .occ   (occ)
  );

  // Next-state and read-issue logic.
  always_comb begin
    state_nxt = state;
    r_en      = !empty_flag && (lvl < LVL_W'(SKID_DEPTH));
`ifdef FIFO_RD_FLUSH_EN
    flush_done_nxt = 1'b0;
`endif
    case (state)
      IDLE: begin
        if (r_en) state_nxt = ACTIVE;
      end
      ACTIVE: begin
        if ((occ == '0) && (infl == '0) && !r_en) state_nxt = IDLE;
      end
`ifdef FIFO_RD_FLUSH_EN
      FLUSH_WAIT: begin
        r_en = !empty_flag;
        if (empty_flag && (infl == '0)) begin
          state_nxt      = IDLE;
          flush_done_nxt = 1'b1;
        end
      end
`endif
      default: state_nxt = IDLE;
    endcase
`ifdef FIFO_RD_FLUSH_EN
    if (clear) state_nxt = FLUSH_WAIT;
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      infl     <= '0;
      rd_count <= '0;
    end else begin
      state <= state_nxt;
      infl  <= FIFO_RD_LAT'(r_en);
      if (pop) rd_count <= rd_count + CNT_W'(1);
    end
  end

`ifdef FIFO_RD_FLUSH_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) flush_done <= 1'b0;
    else        flush_done <= flush_done_nxt;
  end
`endif

endmodule

// File: tb/tb_fifo_read_ctrl.sv
// Directed self-checking bench for fifo_read_ctrl with a behavioural FIFO model.
// Flush scenario is compiled in when FIFO_RD_FLUSH_EN is defined.
module tb_fifo_read_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        empty_flag;
  logic [7:0]  data_out;
  logic        m_ready = 1'b1;
  logic        flush = 1'b0;
  logic        r_en, m_valid, r_en4, m_valid4;
  logic [7:0]  m_data, m_data4;
  logic [15:0] rd_count;
  logic [3:0]  rd_count4;
`ifdef FIFO_RD_FLUSH_EN
  logic        flush_done, flush_done4;
`endif

  int tests = 0;
  int fails = 0;
  logic [7:0] fifo_q[$];
  logic [7:0] exp_q[$];
  logic       stall_q = 1'b0;
  logic [7:0] stall_data = 8'h00;

  always #35 clk = ~clk;

  fifo_read_ctrl #(.WIDTH(8), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .empty_flag(empty_flag), .data_out(data_out),
    .r_en(r_en), .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready),
    .rd_count(rd_count)
`ifdef FIFO_RD_FLUSH_EN
    , .flush(flush), .flush_done(flush_done)
`endif
  );

  fifo_read_ctrl #(.WIDTH(8), .CNT_W(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .empty_flag(empty_flag), .data_out(data_out),
    .r_en(r_en4), .m_data(m_data4), .m_valid(m_valid4), .m_ready(m_ready),
    .rd_count(rd_count4)
`ifdef FIFO_RD_FLUSH_EN
    , .flush(flush), .flush_done(flush_done4)
`endif
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // FIFO model: registered empty flag, one-cycle read latency.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      empty_flag <= 1'b1;
      data_out   <= 8'h00;
    end else begin
      if (r_en) begin
        check("ren_while_empty", 32'(empty_flag), 32'd0);
        if (fifo_q.size() != 0) data_out <= fifo_q.pop_front();
      end
      empty_flag <= (fifo_q.size() == 0);
    end
  end

  // Stream scoreboard and stall-stability monitor.
  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      if (stall_q) begin
        check("stall_valid", 32'(m_valid), 32'd1);
        check("stall_data", 32'(m_data), 32'(stall_data));
      end
      if (m_valid && m_ready) begin
        check("sb_underrun", 32'(exp_q.size() != 0), 32'd1);
        if (exp_q.size() != 0) check("sb_data", 32'(m_data), 32'(exp_q.pop_front()));
      end
      stall_q    <= m_valid && !m_ready && !flush;
      stall_data <= m_data;
    end else begin
      stall_q <= 1'b0;
    end
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
    $fatal(1);
  end

  task automatic do_reset();
    rst_n   = 1'b0;
    m_ready = 1'b1;
    flush   = 1'b0;
    fifo_q.delete();
    exp_q.delete();
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_r_en", 32'(r_en), 32'd0);
    check("rst_m_valid", 32'(m_valid), 32'd0);
    check("rst_m_data", 32'(m_data), 32'd0);
    check("rst_rd_count", 32'(rd_count), 32'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic push_word(input logic [7:0] w, input bit track);
    fifo_q.push_back(w);
    if (track) exp_q.push_back(w);
  endtask

  // Leaves the bench at the negedge of the first cycle with empty_flag low.
  task automatic wait_fall(input string tag);
    int n = 0;
    while (empty_flag && n < 20) begin
      @(negedge clk);
      n++;
    end
    check(tag, 32'(empty_flag), 32'd0);
  endtask

  initial begin
    // 1: idle after reset with an empty FIFO
    do_reset();
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("t1_r_en", 32'(r_en), 32'd0);
      check("t1_m_valid", 32'(m_valid), 32'd0);
      check("t1_rd_count", 32'(rd_count), 32'd0);
    end

    // 2: two words, two-cycle latency from empty falling
    do_reset();
    @(posedge clk);
    #1;
    push_word(8'hFF, 1'b1);
    push_word(8'h81, 1'b1);
    wait_fall("t2_fall");
    check("t2_valid_t0", 32'(m_valid), 32'd0);
    @(negedge clk);
    check("t2_valid_t1", 32'(m_valid), 32'd0);
    @(negedge clk);
    check("t2_valid_t2", 32'(m_valid), 32'd1);
    check("t2_data_t2", 32'(m_data), 32'h0FF);
    @(negedge clk);
    check("t2_valid_t3", 32'(m_valid), 32'd1);
    check("t2_data_t3", 32'(m_data), 32'h081);
    @(negedge clk);
    check("t2_valid_t4", 32'(m_valid), 32'd0);
    check("t2_rd_count", 32'(rd_count), 32'd2);
    check("t2_drained", 32'(exp_q.size()), 32'd0);

    // 3: 32 random words at full rate
    do_reset();
    @(posedge clk);
    #1;
    for (int i = 0; i < 32; i++) push_word(8'($urandom_range(0, 255)), 1'b1);
    wait_fall("t3_fall");
    @(negedge clk);
    for (int i = 0; i < 32; i++) begin
      @(negedge clk);
      check("t3_stream_valid", 32'(m_valid), 32'd1);
    end
    @(negedge clk);
    check("t3_valid_end", 32'(m_valid), 32'd0);
    check("t3_rd_count", 32'(rd_count), 32'd32);
    check("t3_drained", 32'(exp_q.size()), 32'd0);

    // 4: back-pressure, toggling ready with a 5-cycle hold-low window
    do_reset();
    @(posedge clk);
    #1;
    for (int i = 0; i < 32; i++) push_word(8'($urandom_range(0, 255)), 1'b1);
    for (int i = 0; i < 400 && exp_q.size() != 0; i++) begin
      @(posedge clk);
      #1 m_ready = (i >= 10 && i < 15) ? 1'b0 : ((i % 2) == 0);
    end
    check("t4_drained", 32'(exp_q.size()), 32'd0);
    m_ready = 1'b1;
    repeat (3) @(negedge clk);
    check("t4_valid_end", 32'(m_valid), 32'd0);
    check("t4_r_en_end", 32'(r_en), 32'd0);
    check("t4_rd_count", 32'(rd_count), 32'd32);

    // 5: 4-bit counter wraps 15 -> 0 -> 1
    do_reset();
    @(posedge clk);
    #1;
    for (int i = 0; i < 17; i++) push_word(8'(i + 8'h10), 1'b1);
    wait_fall("t5_fall");
    repeat (17) @(negedge clk);
    check("t5_cnt4_15", 32'(rd_count4), 32'd15);
    @(negedge clk);
    check("t5_cnt4_0", 32'(rd_count4), 32'd0);
    @(negedge clk);
    check("t5_cnt4_1", 32'(rd_count4), 32'd1);
    check("t5_cnt16_17", 32'(rd_count), 32'd17);
    check("t5_drained", 32'(exp_q.size()), 32'd0);

`ifdef FIFO_RD_FLUSH_EN
    // 6: flush with a stalled consumer, then normal delivery
    begin
      int done_cnt = 0;
      int valid_cnt = 0;
      do_reset();
      m_ready = 1'b0;
      @(posedge clk);
      #1;
      for (int i = 0; i < 10; i++) push_word(8'(8'hA0 + i), 1'b0);
      wait_fall("t6_fall");
      repeat (4) @(negedge clk);
      check("t6_buffered_valid", 32'(m_valid), 32'd1);
      check("t6_buffered_head", 32'(m_data), 32'h0A0);
      @(posedge clk);
      #1 flush = 1'b1;
      @(posedge clk);
      #1 flush = 1'b0;
      @(negedge clk);
      check("t6_valid_after_flush", 32'(m_valid), 32'd0);
      for (int i = 0; i < 40; i++) begin
        if (flush_done) done_cnt++;
        if (m_valid) valid_cnt++;
        @(negedge clk);
      end
      check("t6_flush_done_pulses", 32'(done_cnt), 32'd1);
      check("t6_no_valid", 32'(valid_cnt), 32'd0);
      check("t6_fifo_drained", 32'(fifo_q.size()), 32'd0);
      check("t6_empty", 32'(empty_flag), 32'd1);
      check("t6_rd_count", 32'(rd_count), 32'd0);
      m_ready = 1'b1;
      @(posedge clk);
      #1 push_word(8'h5A, 1'b1);
      wait_fall("t6_fall2");
      repeat (2) @(negedge clk);
      check("t6_post_valid", 32'(m_valid), 32'd1);
      check("t6_post_data", 32'(m_data), 32'h05A);
      @(negedge clk);
      check("t6_post_count", 32'(rd_count), 32'd1);
      check("t6_post_drained", 32'(exp_q.size()), 32'd0);
    end
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
